// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op encodings, the multi-cycle
// FSM state encoding and default datapath widths.
package ex_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDestW = 5;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSll  = 4'd6,
    AluSrl  = 4'd7,
    AluMul  = 4'd8,
    AluDivu = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op == AluMul) || (op == AluDivu);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle, plus the IDLE/MUL/DIV sequencer and iteration counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_i, op_i   launch a MUL/DIVU when idle (op_i == AluDivu selects divide)
//   a_i, b_i        operands, sampled on start
//   abort_i         synchronous kill: back to idle, counter cleared, no done
//   busy_o          unit is iterating (registered-state decode)
//   done_o/result_o final iteration this cycle; result_o is valid with done_o
module mul_div_unit
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // x: product accumulator / partial remainder
  // y: shifted multiplicand / dividend bits shifting out, quotient shifting in
  // z: multiplier (shifted right) / divisor
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0] x_step, y_step;
  logic [WIDTH:0]   rem_shift, rem_diff;

  // One iteration of the active algorithm, computed from the current state.
  always_comb begin
    rem_shift = {x_q, y_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, z_q};
    if (state_q == StDiv) begin
      // Negative trial difference means restore; a zero divisor never goes
      // negative, so every quotient bit is set and the result is all-ones.
      if (rem_diff[WIDTH]) begin
        x_step = rem_shift[WIDTH-1:0];
        y_step = y_q << 1;
      end else begin
        x_step = rem_diff[WIDTH-1:0];
        y_step = (y_q << 1) | WIDTH'(1);
      end
    end else begin
      x_step = x_q + (z_q[0] ? y_q : '0);
      y_step = y_q << 1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    done_o  = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = (op_i == AluDivu) ? StDiv : StMul;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = a_i;
            z_d     = b_i;
          end
        end
        StMul, StDiv: begin
          x_d = x_step;
          y_d = y_step;
          z_d = (state_q == StMul) ? (z_q >> 1) : z_q;
          if (cnt_q == LastCnt) begin
            done_o  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign result_o = (state_q == StDiv) ? y_step : x_step;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative MUL/DIVU via mul_div_unit, and
// the pipeline register feeding the memory stage.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   valid_in, aluOp, srcA, srcB   op and operands
//   writedata_in, dest_in,
//   read_in, write_in, regwrite_in  controls carried to the memory stage
//   flush                         kill the in-flight op
//   stall                         upstream holds while a MUL/DIVU iterates
//   valid_out, aluResult, writedata, dest, read, write, regwrite  registered
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEST_W = DefDestW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [3:0]        aluOp,
  input  logic [WIDTH-1:0]  srcA,
  input  logic [WIDTH-1:0]  srcB,
  input  logic [WIDTH-1:0]  writedata_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              read_in,
  input  logic              write_in,
  input  logic              regwrite_in,
  input  logic              flush,
  output logic              stall,
  output logic              valid_out,
  output logic [WIDTH-1:0]  aluResult,
  output logic [WIDTH-1:0]  writedata,
  output logic [DEST_W-1:0] dest,
  output logic              read,
  output logic              write,
  output logic              regwrite
);

  logic             accept, is_md, md_done;
  logic [WIDTH-1:0] md_result, alu_result;
  logic [4:0]       shamt;

  // Controls of the MUL/DIVU in flight, released with its result.
  logic [WIDTH-1:0]  pend_wd_q;
  logic [DEST_W-1:0] pend_dest_q;
  logic              pend_read_q, pend_write_q, pend_regwrite_q;

  logic              valid_q, valid_d, read_q, read_d, write_q, write_d;
  logic              regwrite_q, regwrite_d;
  logic [WIDTH-1:0]  result_q, result_d, wd_q, wd_d;
  logic [DEST_W-1:0] dest_q, dest_d;

  assign is_md  = is_multi_cycle(aluOp);
  assign accept = valid_in && !stall && !flush;
  assign shamt  = srcB[4:0];

  mul_div_unit #(
    .WIDTH (WIDTH)
  ) u_mul_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept && is_md),
    .op_i     (aluOp),
    .a_i      (srcA),
    .b_i      (srcB),
    .abort_i  (flush),
    .busy_o   (stall),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    alu_result = '0;
    case (aluOp)
      AluAdd:  alu_result = srcA + srcB;
      AluSub:  alu_result = srcA - srcB;
      AluAnd:  alu_result = srcA & srcB;
      AluOr:   alu_result = srcA | srcB;
      AluXor:  alu_result = srcA ^ srcB;
      AluSlt:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      AluSll:  alu_result = srcA << shamt;
      AluSrl:  alu_result = srcA >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Data fields hold when nothing completes; controls drop to zero.
  always_comb begin
    valid_d    = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    regwrite_d = 1'b0;
    result_d   = result_q;
    wd_d       = wd_q;
    dest_d     = dest_q;
    if (flush) begin
      // Kill wins over both completion and acceptance.
    end else if (md_done) begin
      valid_d    = 1'b1;
      result_d   = md_result;
      wd_d       = pend_wd_q;
      dest_d     = pend_dest_q;
      read_d     = pend_read_q;
      write_d    = pend_write_q;
      regwrite_d = pend_regwrite_q;
    end else if (accept && !is_md) begin
      valid_d    = 1'b1;
      result_d   = alu_result;
      wd_d       = writedata_in;
      dest_d     = dest_in;
      read_d     = read_in;
      write_d    = write_in;
      regwrite_d = regwrite_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= 1'b0;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      regwrite_q      <= 1'b0;
      result_q        <= '0;
      wd_q            <= '0;
      dest_q          <= '0;
      pend_wd_q       <= '0;
      pend_dest_q     <= '0;
      pend_read_q     <= 1'b0;
      pend_write_q    <= 1'b0;
      pend_regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      read_q     <= read_d;
      write_q    <= write_d;
      regwrite_q <= regwrite_d;
      result_q   <= result_d;
      wd_q       <= wd_d;
      dest_q     <= dest_d;
      if (accept && is_md) begin
        pend_wd_q       <= writedata_in;
        pend_dest_q     <= dest_in;
        pend_read_q     <= read_in;
        pend_write_q    <= write_in;
        pend_regwrite_q <= regwrite_in;
      end
    end
  end

  assign valid_out = valid_q;
  assign aluResult = result_q;
  assign writedata = wd_q;
  assign dest      = dest_q;
  assign read      = read_q;
  assign write     = write_q;
  assign regwrite  = regwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table plus hand sequences for flush, reset and a
// mixed stream. A scoreboard queue holds expected results and the edge at
// which each must appear; a monitor pops on every valid_out.
module tb_ex_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [3:0]    aluOp = '0;
  logic [W-1:0]  srcA = '0, srcB = '0, writedata_in = '0;
  logic [4:0]    dest_in = '0;
  logic          read_in = 1'b0, write_in = 1'b0, regwrite_in = 1'b0, flush = 1'b0;
  logic          stall, valid_out, read, write, regwrite;
  logic [W-1:0]  aluResult, writedata;
  logic [4:0]    dest;

  ex_stage #(
    .WIDTH  (W),
    .DEST_W (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .aluOp        (aluOp),
    .srcA         (srcA),
    .srcB         (srcB),
    .writedata_in (writedata_in),
    .dest_in      (dest_in),
    .read_in      (read_in),
    .write_in     (write_in),
    .regwrite_in  (regwrite_in),
    .flush        (flush),
    .stall        (stall),
    .valid_out    (valid_out),
    .aluResult    (aluResult),
    .writedata    (writedata),
    .dest         (dest),
    .read         (read),
    .write        (write),
    .regwrite     (regwrite)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] wd;
    logic [4:0]   dest;
    logic [2:0]   ctrl;
    int           out_edge;
  } exp_t;

  exp_t         sbq[$];
  vec_t         vecs[18];
  int           errors = 0;
  int           checks = 0;
  int           next_free = 0;
  logic [W-1:0] last_res = '0, last_wd = '0;
  logic [4:0]   last_dest = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected valid_out: got result %h, expected no output (edge %0d)",
                   aluResult, cyc);
        end else begin
          e = sbq.pop_front();
          chk("aluResult", aluResult, e.res);
          chk("writedata", writedata, e.wd);
          chk("dest", 32'(dest), 32'(e.dest));
          chk("read/write/regwrite", 32'({read, write, regwrite}), 32'(e.ctrl));
          chk("output edge", 32'(cyc), 32'(e.out_edge));
          last_res  = e.res;
          last_wd   = e.wd;
          last_dest = e.dest;
        end
      end else begin
        chk("idle controls", 32'({read, write, regwrite}), 32'd0);
        chk("held aluResult", aluResult, last_res);
        chk("held writedata", writedata, last_wd);
        chk("held dest", 32'(dest), 32'(last_dest));
      end
    end
  endtask

  task automatic idle();
    valid_in    = 1'b0;
    read_in     = 1'b0;
    write_in    = 1'b0;
    regwrite_in = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] wd, input logic [4:0] d, input logic [2:0] ctrl);
    valid_in     = 1'b1;
    aluOp        = op;
    srcA         = a;
    srcB         = b;
    writedata_in = wd;
    dest_in      = d;
    {read_in, write_in, regwrite_in} = ctrl;
  endtask

  // Holds the op on the inputs until the model says it is accepted; stall must
  // agree with the model every cycle.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] wd, input logic [4:0] d, input logic [2:0] ctrl,
                      input logic [W-1:0] exp);
    int   acc_edge;
    bit   md;
    exp_t e;
    md       = (op == 4'd8) || (op == 4'd9);
    acc_edge = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    drive(op, a, b, wd, d, ctrl);
    while (cyc + 1 < acc_edge) begin
      chk("stall while busy", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("stall at accept", 32'(stall), 32'd0);
    e.res      = exp;
    e.wd       = wd;
    e.dest     = d;
    e.ctrl     = ctrl;
    e.out_edge = acc_edge + (md ? W : 0);
    sbq.push_back(e);
    next_free = acc_edge + (md ? W + 1 : 1);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    while (cyc + 1 < next_free) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005};
    vecs[2]  = '{4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[3]  = '{4'd2, 32'hF0F0_FF00, 32'h0FF0_0F0F, 32'h00F0_0F00};
    vecs[4]  = '{4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[5]  = '{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[6]  = '{4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[7]  = '{4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{4'd6, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
    vecs[9]  = '{4'd7, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    vecs[10] = '{4'd12, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
    vecs[11] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{4'd8, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[13] = '{4'd8, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[14] = '{4'd9, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
    vecs[15] = '{4'd9, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[16] = '{4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[17] = '{4'd0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030};

    #1 rst = 1'b0;
    #1;
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset aluResult", aluResult, 32'd0);
    chk("reset dest", 32'(dest), 32'd0);
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    next_free = cyc + 1;

    // Table: back-to-back single-cycle ops, MUL/DIVU with the next op held.
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, 32'hC0DE_0000 + 32'(i), 5'(i + 1),
           3'(i % 8), vecs[i].exp);
    end
    idle();

    // Flush at cycle 10 of a DIVU: nothing comes out, the stage frees up.
    settle();
    drive(4'd9, 32'd1000, 32'd3, 32'h0, 5'd7, 3'b001);
    @(posedge clk);
    #1;
    idle();
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("stall after flush", 32'(stall), 32'd0);
    chk("valid_out after flush", 32'(valid_out), 32'd0);
    next_free = cyc + 1;
    send(4'd0, 32'd2, 32'd3, 32'h1111_2222, 5'd9, 3'b001, 32'd5);
    idle();

    // Reset at cycle 5 of a MUL: outputs clear at once, no result later.
    settle();
    drive(4'd8, 32'h0001_0000, 32'd3, 32'h0, 5'd4, 3'b001);
    @(posedge clk);
    #1;
    idle();
    repeat (4) @(posedge clk);
    #1;
    rst       = 1'b0;
    last_res  = '0;
    last_wd   = '0;
    last_dest = '0;
    #1;
    chk("async reset valid_out", 32'(valid_out), 32'd0);
    chk("async reset stall", 32'(stall), 32'd0);
    chk("async reset aluResult", aluResult, 32'd0);
    chk("async reset writedata", writedata, 32'd0);
    chk("async reset dest", 32'(dest), 32'd0);
    chk("async reset controls", 32'({read, write, regwrite}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    next_free = cyc + 1;
    send(4'd8, 32'd3, 32'd3, 32'h0000_0ABC, 5'd11, 3'b001, 32'd9);
    idle();

    // Stream: ADD, LW, MUL, SW; SW is held until the MUL completes.
    send(4'd0, 32'd10, 32'd20, 32'h0, 5'd1, 3'b001, 32'd30);
    send(4'd0, 32'd100, 32'd4, 32'h0, 5'd2, 3'b101, 32'd104);
    send(4'd8, 32'd3, 32'd5, 32'h0, 5'd3, 3'b001, 32'd15);
    send(4'd0, 32'h200, 32'd8, 32'hDEAD_BEEF, 5'd0, 3'b010, 32'h208);
    idle();

    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter DEST_W, default 5, destination register index width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have inputs valid_in (1, op present), aluOp (4, operation), srcA and srcB (WIDTH, operands), writedata_in (WIDTH, store data), dest_in (DEST_W), read_in, write_in, regwrite_in (1 each, memory/writeback controls).
REQ-006 SHALL have input flush, 1, synchronous kill of the in-flight op.
REQ-007 SHALL have output stall, 1, upstream must hold its inputs while high.
REQ-008 SHALL have registered outputs valid_out (1), aluResult (WIDTH), writedata (WIDTH), dest (DEST_W), read, write, regwrite (1 each), feeding the memory stage.

Function
REQ-009 SHALL implement aluOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL, 8 MUL, 9 DIVU; 10-15 SHALL produce 0.
REQ-010 SHALL use srcB[4:0] as the shift amount; ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-011 An op is accepted on a rising edge where valid_in=1, stall=0, flush=0.
REQ-012 Ops 0-7 and 10-15 SHALL have 1-cycle latency: accepted at edge N -> outputs updated and valid_out=1 after edge N.
REQ-013 MUL SHALL return the low WIDTH bits of the unsigned product via iterative shift-add, one bit per cycle.
REQ-014 DIVU SHALL return the unsigned quotient via restoring division, one bit per cycle; srcB=0 SHALL yield all-ones.
REQ-015 FSM states: IDLE, MUL, DIV. IDLE->MUL/DIV on acceptance of op 8/9; MUL/DIV->IDLE when the iteration counter reaches WIDTH-1.
REQ-016 MUL/DIV accepted at edge N SHALL produce valid_out=1 after edge N+WIDTH (32 cycles at default).
REQ-017 stall SHALL equal (state != IDLE), a registered-state decode only, no combinational path from valid_in.
REQ-018 Inputs SHALL be ignored while stall=1; operands and controls SHALL be captured on acceptance.
REQ-019 valid_out SHALL be high exactly one cycle per completed op.
REQ-020 When valid_out=0, read, write and regwrite SHALL be 0; aluResult, writedata and dest SHALL hold their last values.
REQ-021 flush SHALL take priority over acceptance and completion: the next edge drives valid_out=0, forces state IDLE, clears the counter, and produces no result.
REQ-022 Back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-023 An op presented on the same edge a MUL/DIV completes SHALL NOT be accepted (stall still 1); it SHALL be accepted on the next edge.

Reset
REQ-024 rst low SHALL immediately force state IDLE, counter 0, stall 0, valid_out 0, read/write/regwrite 0, aluResult/writedata 0, dest 0.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the op with no result after release.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Shared package ex_pkg SHALL hold the aluOp encodings, the FSM state encoding and default WIDTH/DEST_W.
REQ-028 The iterative multiply/divide datapath and counter SHALL be the sub-module mul_div_unit (start, op, operands in; done, result out; abort input for flush/reset).
REQ-029 Single-cycle ALU logic and the output pipeline register SHALL reside in ex_stage.

Verification
REQ-030 ADD 0xFFFFFFFF+1 -> aluResult 0x0 after 1 edge; SLT 0xFFFFFFFF,1 -> 1; SRL 0x80000000 by 31 -> 0x1.
REQ-031 MUL 0x10000,0x10000 -> stall high 32 cycles, aluResult 0x0 with one valid_out pulse at edge N+32; MUL 7,6 -> 42.
REQ-032 DIVU 100,7 -> 14 at edge N+32; DIVU 5,0 -> 0xFFFFFFFF.
REQ-033 Flush at cycle 10 of a DIVU -> no valid_out, stall low next cycle, following ADD 2+3 -> 5 after 1 edge.
REQ-034 rst low at cycle 5 of a MUL -> all outputs 0 immediately; after release a MUL 3,3 -> 9 after 32 edges.
REQ-035 Stream ADD, LW control (read_in=1), MUL, SW (write_in=1) -> results in order, read/write asserted only with valid_out, SW accepted the cycle after MUL completes.
